// File: rtl/fpu_divsqrt_arbiter.sv
// Two-requester arbiter in front of a shared iterative div/sqrt unit.
// One operation is in flight at a time. A divide by +/-0 is answered locally
// without using the unit. A watchdog returns a NaN if the unit never finishes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         operation handshake per requester (ready is
//                            combinational from state, grant and valids)
//   reqN_op/a/b/mode         0=a/b, 1=sqrt(a); operands; rounding mode
//   rspN_valid/ready         result handshake per requester
//   rspN_result/timeout      result word; set when the result is a watchdog NaN
//   unit_start/op/a/b/mode   launch pulse and registered operands to the unit
//   unit_done/result         completion pulse and result from the unit
module fpu_divsqrt_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_mode,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_timeout,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_timeout,
    output logic        unit_start,
    output logic        unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic [1:0]  unit_mode,
    input  logic        unit_done,
    input  logic [31:0] unit_result
);
    localparam int unsigned CNT_W  = 8;
    localparam logic [31:0] NAN    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t            state, state_next;
    logic              owner, last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       result;
    logic              timeout_flag;
    logic              rsp0_valid_q, rsp1_valid_q;

    logic              grant1, accept, bypass, done_take, wd_hit, rsp_take;
    logic              sel_op;
    logic [31:0]       sel_a, sel_b, bypass_result;
    logic [1:0]        sel_mode;

    assign sel_op   = grant1 ? req1_op   : req0_op;
    assign sel_a    = grant1 ? req1_a    : req0_a;
    assign sel_b    = grant1 ? req1_b    : req0_b;
    assign sel_mode = grant1 ? req1_mode : req0_mode;

    // x/0 gives signed infinity, 0/0 gives NaN
    assign bypass_result = (sel_a[30:0] == 31'd0) ? NAN
                         : {sel_a[31] ^ sel_b[31], 8'hFF, 23'd0};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, grant and handshake decode
    always_comb begin
        state_next = state;
        grant1     = 1'b0;
        accept     = 1'b0;
        bypass     = 1'b0;
        done_take  = 1'b0;
        wd_hit     = 1'b0;
        rsp_take   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    // last_grant=1 means req1 won last time, so req0 wins a tie
                    grant1     = req1_valid && (!req0_valid || !last_grant);
                    req0_ready = req0_valid && !grant1;
                    req1_ready = grant1;
                    accept     = req0_valid || req1_valid;
                    if (accept) begin
                        bypass     = !sel_op && (sel_b[30:0] == 31'd0);
                        state_next = bypass ? RESPOND : ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (unit_done) begin
                    done_take  = 1'b1;
                    state_next = RESPOND;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    wd_hit     = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                if (owner ? rsp1_ready : rsp0_ready) begin
                    rsp_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand, watchdog and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            result       <= '0;
            timeout_flag <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            unit_start   <= 1'b0;
            unit_op      <= 1'b0;
            unit_a       <= '0;
            unit_b       <= '0;
            unit_mode    <= '0;
        end else begin
            unit_start <= accept && !bypass;
            // cnt is 0 during ISSUE and counts cycles since the launch
            if (state == ISSUE || state == WAIT) cnt <= cnt + CNT_W'(1);
            if (accept) begin
                owner      <= grant1;
                last_grant <= grant1;
                unit_op    <= sel_op;
                unit_a     <= sel_a;
                unit_b     <= sel_b;
                unit_mode  <= sel_mode;
                cnt        <= '0;
                if (bypass) begin
                    result       <= bypass_result;
                    timeout_flag <= 1'b0;
                    rsp0_valid_q <= !grant1;
                    rsp1_valid_q <= grant1;
                end
            end
            if (done_take || wd_hit) begin
                result       <= done_take ? unit_result : NAN;
                timeout_flag <= wd_hit;
                rsp0_valid_q <= !owner;
                rsp1_valid_q <= owner;
            end
            if (rsp_take) begin
                rsp0_valid_q <= 1'b0;
                rsp1_valid_q <= 1'b0;
            end
        end
    end

    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_result  = result;
    assign rsp1_result  = result;
    assign rsp0_timeout = timeout_flag;
    assign rsp1_timeout = timeout_flag;

endmodule

// File: doc/fpu_divsqrt_arbiter.md
FPU_DIVSQRT_ARBITER -- requirements
Module: fpu_divsqrt_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles waited in WAIT for unit_done before a forced NaN response; legal range 2..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_op  in  1  0=divide a/b, 1=square root of a (b ignored).
REQ-007 reqN_a, reqN_b  in  32 each  IEEE single operands.
REQ-008 reqN_mode  in  2  rounding mode (EVEN=0, DOWN=1, UP=2, ZERO=3), passed to the unit.
REQ-009 rspN_valid  out  1  result pending for requester N.
REQ-010 rspN_ready  in  1  requester N consumes the result.
REQ-011 rspN_result  out  32  result word.
REQ-012 rspN_timeout  out  1  result is a forced NaN from the watchdog.
REQ-013 unit_start  out  1  one-cycle launch pulse to the shared iterative div/sqrt unit.
REQ-014 unit_op, unit_a, unit_b, unit_mode  out  1/32/32/2  registered operands; stable from unit_start until the operation ends.
REQ-015 unit_done  in  1  one-cycle completion pulse from the unit.
REQ-016 unit_result  in  32  valid only while unit_done=1.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESPOND; exactly one active operation at any time.
REQ-018 IDLE: reqN_ready=1 only for the granted requester; all ready outputs 0 in every other state.
REQ-019 Grant: a single valid requester wins; if both are valid, the one not granted last wins; last_grant updates on every acceptance.
REQ-020 Acceptance (valid&ready) at cycle N latches op/a/b/mode and the owner ID; next state ISSUE, unless the bypass path applies.
REQ-021 Bypass: divide with b exponent=0 and mantissa=0 skips the unit; result = NaN (32'hFFFF_FFFF) if a is also zero, otherwise infinity with sign a[31]^b[31] (7F80_0000/FF80_0000); next state RESPOND at N+1.
REQ-022 ISSUE: unit_start=1 for exactly that cycle; next state WAIT; the watchdog counter clears to 0.
REQ-023 WAIT: the counter increments each cycle; on unit_done, unit_result is captured, timeout flag=0, next state RESPOND.
REQ-024 WAIT: when the counter reaches TIMEOUT-1 without unit_done, result=32'hFFFF_FFFF, timeout flag=1, next state RESPOND.
REQ-025 unit_done in the same cycle as the limit: done wins; the unit result is captured and timeout=0.
REQ-026 unit_done outside WAIT is ignored; no state or result change.
REQ-027 RESPOND: rspN_valid=1 for the owner only, with result and timeout held stable; the other rsp valid stays 0.
REQ-028 RESPOND: on rspN_ready for the owner, next state IDLE; a new acceptance is possible at the earliest one cycle later.
REQ-029 Latency through the unit: accept N, start N+1, done at D, rsp_valid from D+1; minimum accept-to-accept interval is 4 cycles.
REQ-030 A non-owner rsp_ready is ignored; a requester's valid held during another's operation is not lost.

Reset
REQ-031 While rst=1: state=IDLE; all ready, rsp_valid, rsp_timeout and unit_start=0; unit_* operands=0; results=0; counter=0; last_grant=1, so req0 wins the first tie.
REQ-032 rst asserted mid-operation in any state aborts the operation with no response; a later stray unit_done is ignored per REQ-026.

Verification
REQ-033 Both valid after reset, req0 div 40400000/3F800000 -> req0 accepted first; unit_start next cycle; unit_done with 40400000 -> rsp0_valid with 40400000, timeout=0; then req1 granted.
REQ-034 req1 div a=3F800000, b=80000000 -> no unit_start; rsp1_result=FF800000 one cycle after accept; a=0, b=0 gives FFFFFFFF.
REQ-035 Unit never asserts done, TIMEOUT=64 -> rsp valid exactly 64 cycles after ISSUE with result FFFFFFFF and timeout=1; a late unit_done is ignored.
REQ-036 rsp0_ready held 0 for 10 cycles while req1 is valid -> rsp0 stable, req1_ready=0 throughout; req1 accepted 1 cycle after the rsp0 handshake.
REQ-037 rst pulsed during WAIT, then unit_done -> no rsp_valid; all outputs at reset values; next request is accepted normally.
REQ-038 unit_done coincident with the watchdog limit -> unit result delivered with timeout=0.
